// File: rtl/qick_xcom_tx.sv
// qick_xcom_tx: XCOM network transmit stage.
// This block accepts one command through a 4-phase req/ack handshake.
// It then serialises the opcode and a length-coded payload onto a
// three-wire link: valid, toggle clock and data. Data is sent MSB first.
// Each bit lasts 2H cycles. The link clock toggles at mid-bit.
module qick_xcom_tx (
  input  logic        x_clk_i,
  input  logic        x_rst_ni,
  input  logic        cmd_net_req_i,
  output logic        cmd_net_ack_o,
  input  logic [7:0]  cmd_op_i,
  input  logic [31:0] cmd_dt_i,
  input  logic [3:0]  tx_cfg_i,
  output logic        tx_vld_o,
  output logic        tx_ck_o,
  output logic        tx_dt_o,
  output logic        tx_busy_o,
  output logic [7:0]  tx_cnt_do
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_TX   = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [39:0] sr_q;        // frame, left aligned; sr_q[39] is on the wire
  logic [5:0]  bit_cnt_q;   // bits remaining after the current one
  logic [3:0]  half_cnt_q;  // cycles left in the current half-bit, minus one
  logic [3:0]  hcfg_q;      // captured H-1
  logic        half_q;      // 0: first half of bit, 1: second half
  logic        ck_q;
  logic        ack_q;
  logic [7:0]  frm_cnt_q;

  logic        capture;
  logic        last_bit;
  logic [39:0] frame_d;
  logic [5:0]  nbits_m1_d;

  // Build the left-aligned frame and its bit count from the length code
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    frame_d    = {cmd_op_i, 32'h0};
    nbits_m1_d = 6'd7;
    case (cmd_op_i[2:1])
      2'b01: begin
        frame_d    = {cmd_op_i, cmd_dt_i[7:0], 24'h0};
        nbits_m1_d = 6'd15;
      end
      2'b10: begin
        frame_d    = {cmd_op_i, cmd_dt_i[15:0], 16'h0};
        nbits_m1_d = 6'd23;
      end
      2'b11: begin
        frame_d    = {cmd_op_i, cmd_dt_i};
        nbits_m1_d = 6'd39;
      end
      default: ;
    endcase
  end

  // Next-state logic: capture in IDLE only when the previous handshake has closed
  always_comb begin
    state_d  = state_q;
    capture  = 1'b0;
    last_bit = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_net_req_i && !ack_q) begin
          capture = 1'b1;
          state_d = ST_TX;
        end
      end
      ST_TX: begin
        if (half_cnt_q == 4'd0 && half_q && bit_cnt_q == 6'd0) begin
          last_bit = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge x_clk_i or negedge x_rst_ni) begin
    if (!x_rst_ni) begin
      state_q <= ST_IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments, so every register samples pre-edge values.
      state_q <= state_d;
    end
  end

  // Shift register, bit/half-bit timing and link clock toggle
  always_ff @(posedge x_clk_i or negedge x_rst_ni) begin
    if (!x_rst_ni) begin
      sr_q       <= '0;
      bit_cnt_q  <= '0;
      half_cnt_q <= '0;
      hcfg_q     <= '0;
      half_q     <= 1'b0;
      ck_q       <= 1'b0;
    end else if (capture) begin
      sr_q       <= frame_d;
      bit_cnt_q  <= nbits_m1_d;
      half_cnt_q <= tx_cfg_i;
      hcfg_q     <= tx_cfg_i;
      half_q     <= 1'b0;
    end else if (state_q == ST_TX) begin
      if (half_cnt_q != 4'd0) begin
        half_cnt_q <= half_cnt_q - 4'd1;
      end else if (!half_q) begin
        half_q     <= 1'b1;
        ck_q       <= ~ck_q;
        half_cnt_q <= hcfg_q;
      end else if (!last_bit) begin
        sr_q       <= {sr_q[38:0], 1'b0};
        bit_cnt_q  <= bit_cnt_q - 6'd1;
        half_q     <= 1'b0;
        half_cnt_q <= hcfg_q;
      end
    end
  end

  // Acknowledge: set on capture, released when the request is seen low, in any state
  always_ff @(posedge x_clk_i or negedge x_rst_ni) begin
    if (!x_rst_ni) begin
      ack_q <= 1'b0;
    end else if (capture) begin
      ack_q <= 1'b1;
    end else if (ack_q && !cmd_net_req_i) begin
      ack_q <= 1'b0;
    end
  end

  // Completed-frame counter, wraps naturally at 8 bits
  always_ff @(posedge x_clk_i or negedge x_rst_ni) begin
    if (!x_rst_ni) begin
      frm_cnt_q <= '0;
    end else if (last_bit) begin
      frm_cnt_q <= frm_cnt_q + 8'd1;
    end
  end

  assign cmd_net_ack_o = ack_q;
  assign tx_vld_o      = (state_q == ST_TX);
  assign tx_busy_o     = (state_q != ST_IDLE);
  assign tx_dt_o       = (state_q == ST_TX) & sr_q[39];
  assign tx_ck_o       = ck_q;
  assign tx_cnt_do     = frm_cnt_q;

endmodule

// File: doc/qick_xcom_tx.md
# qick_xcom_tx

Network transmit stage of the XCOM command path. Consumes the network command request, the 8-bit opcode and the 32-bit data word from the command arbitration stage, and returns a 4-phase acknowledge. Serializes the opcode plus a length-coded data payload onto a three-wire link (valid, toggle clock, data) toward neighbouring boards, in the x_clk_i domain.

## Interface
- No parameters. Bit half-period is runtime-configured through `tx_cfg_i`.
- `x_clk_i` in 1: transmit clock; the only clock.
- `x_rst_ni` in 1: **asynchronous, active-low reset.** Clears every register immediately; deassertion is synchronous to x_clk_i upstream.
- `cmd_net_req_i` in 1: network command request, level, 4-phase.
- `cmd_net_ack_o` out 1: acknowledge back to the command stage.
- `cmd_op_i` in 8: opcode. Bits [2:1] are the payload length code.
- `cmd_dt_i` in 32: payload word.
- `tx_cfg_i` in 4: half-period H = tx_cfg_i+1 cycles (1..16). Sampled at capture only.
- `tx_vld_o` out 1: high for the whole frame.
- `tx_ck_o` out 1: link clock. Toggles once per bit at mid-bit. Keeps its level between frames.
- `tx_dt_o` out 1: serial data, MSB first.
- `tx_busy_o` out 1: state ≠ IDLE.
- `tx_cnt_do` out 8: frames completed, wraps 255→0 (debug).

## Operation
- Reset values: all outputs 0, state IDLE, tx_ck_o 0, counter 0.
- Length code op[2:1]:
  - 00 → 0 payload bits
  - 01 → dt[7:0]
  - 10 → dt[15:0]
  - 11 → dt[31:0]
- Frame bits N = 8 + payload bits (8, 16, 24, 40). Shift order: op[7]..op[0], then the payload from its MSB down to bit 0.
- States:
  - **IDLE:** if cmd_net_req_i=1 and cmd_net_ack_o=0, then capture op, dt and tx_cfg_i into a 40-bit shift register, load the bit counter with N−1, and go to TX.
  - **TX:** each bit is held for 2H cycles. At the end of the last bit, go to IDLE and increment tx_cnt_do.
- Acknowledge:
  - Set on capture.
  - Cleared on the first cycle cmd_net_req_i is sampled 0 while ack=1. This is independent of state, so the release can happen during TX.
- New capture requires IDLE **and** ack=0. A request that stays high after the frame ends is not re-accepted until the full 4-phase cycle completes.
- cmd_op_i and cmd_dt_i are sampled only on the capture edge. Later changes to the inputs do not affect the frame in flight.
- Bit and half-period counters are sized for 40 bits and for H ≤ 16. There is no overflow path.
- Reset asserted mid-frame:
  - Outputs drop to 0 asynchronously and the frame is abandoned. No partial count increment.
  - After reset releases, a still-high request is treated as new.

## Timing
- Request sampled high at edge E:
  - After E: cmd_net_ack_o=1, tx_busy_o=1, tx_vld_o=1, and tx_dt_o = bit 0 of the frame (op[7]).
- Bit k:
  - tx_dt_o is updated at edge E + k·2H.
  - tx_ck_o toggles at edge E + k·2H + H.
- Frame end at edge E + N·2H: tx_vld_o=0, tx_dt_o=0, tx_busy_o=0, and tx_cnt_do increments. All of these happen on the same edge.
- Ack falls on the edge after the request is first sampled low. Minimum handshake is req high 1 cycle → ack 1 cycle later → ack low 1 cycle after req low.
- Earliest next capture: the edge after both IDLE and ack=0 hold. This gives at least one cycle with tx_vld_o=0 between frames.
- Total frame latency: N·2H cycles. Example: op code 11, H=1 → 80 cycles.

## Test plan
- **Reset:** assert x_rst_ni=0 mid-TX → all outputs 0 in the same cycle (async). After release, tx_ck_o=0 and tx_cnt_do=0.
- **Minimal frame:** op=0xA1 (len 00), tx_cfg=0 →
  - tx_vld_o high for 16 cycles.
  - tx_dt_o sequence 1,0,1,0,0,0,0,1, each bit held 2 cycles.
  - tx_ck_o makes 8 toggles, each at mid-bit.
  - tx_cnt_do=1.
- **Full frame:** op=0x06 (len 11), dt=0xDEADBEEF, tx_cfg=3 →
  - 40 bits, each 8 cycles, 320 cycles total.
  - The payload bits reproduce 0xDEADBEEF MSB first.
  - Changing cmd_dt_i after capture has no effect.
- **Handshake held:** req held high through the whole frame → ack stays 1, no second frame starts. Drop req → ack 0 one edge later. Raise req again → a new frame starts.
- **Early release:** req pulses 1 cycle with op len 01 → ack falls during TX, the frame completes (16 bits). A second req asserted during TX is captured on the first cycle of IDLE.
- **Counter wrap:** 256 back-to-back len-00 frames → tx_cnt_do returns to 0.
